// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared types and constants for the UART transmit controller.
//            Holds the controller state enum, the default data width and a
//            helper that sizes the serializer bit counter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Bit-counter width for a given number of data bits (never below 1).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Shift register plus bit counter for the UART data field.
//            ser_out always presents the next data bit (LSB first); the
//            controller registers it into the TX line as it shifts.
// Ports    : CLK, RST      - bit clock, async active-low reset
//            load          - capture P_DATA, clear the counter
//            shift_en      - advance one data bit
//            P_DATA        - parallel data
//            ser_out       - bit to be driven on the next bit period
//            ser_done      - high during the last data bit period
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  ser_out,
  output logic                  ser_done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_primed;

  // The first shift happens on the START->DATA edge, when bit 0 moves onto
  // the line; it does not count. r_primed marks that the line now carries a
  // data bit, so r_cnt equals the index of the bit currently on the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (load) begin
      r_shreg  <= P_DATA;
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (shift_en) begin
      r_shreg <= r_shreg >> 1;
      if (ser_done) begin
        r_cnt    <= '0;
        r_primed <= 1'b0;
      end else if (r_primed) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_primed <= 1'b1;
      end
    end
  end

  assign ser_out  = r_shreg[0];
  assign ser_done = r_primed && (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit controller. Frames a parallel byte as
//            start, data (LSB first), optional parity, stop bit(s) and drives
//            a registered TX line. Requests arriving while busy are dropped.
// Macro    : UART_TX_STOP2_EN - when defined, the stop field lasts 2 bits.
// Ports    : CLK, RST      - bit clock, async active-low reset
//            P_DATA        - parallel data, sampled on the accept cycle
//            Data_Valid    - request strobe, accepted only when idle
//            PAR_EN        - parity enable, sampled on the accept cycle
//            par_bit       - parity from the parity calculator (START cycle)
//            TX_OUT        - registered serial line, idles high
//            busy          - registered, high for the whole frame
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e r_state;
  tx_state_e w_next_state;
  logic      r_tx;
  logic      r_busy;
  logic      r_par;
  logic      r_par_en;
  logic      w_next_tx;
  logic      w_next_busy;
  logic      w_load;
  logic      w_shift;
  logic      w_ser_out;
  logic      w_ser_done;
  logic      w_stop_last;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (w_load),
    .shift_en (w_shift),
    .P_DATA   (P_DATA),
    .ser_out  (w_ser_out),
    .ser_done (w_ser_done)
  );

`ifdef UART_TX_STOP2_EN
  // Low in the first stop period, high in the second.
  logic r_stop_second;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stop_second <= 1'b0;
    end else if (r_state == STOP) begin
      r_stop_second <= ~r_stop_second;
    end else begin
      r_stop_second <= 1'b0;
    end
  end

  assign w_stop_last = r_stop_second;
`else
  assign w_stop_last = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_next_tx;
      r_busy  <= w_next_busy;
      if (w_load) begin
        r_par_en <= PAR_EN;
      end
      // Parity is valid upstream only during START; hold our own copy.
      if (r_state == START) begin
        r_par <= par_bit;
      end
    end
  end

  // Outputs are registered: each branch sets the line value for the state
  // being entered, so TX_OUT lines up with r_state.
  always_comb begin
    w_next_state = r_state;
    w_next_tx    = 1'b1;
    w_next_busy  = 1'b1;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_next_busy = 1'b0;
        if (Data_Valid) begin
          w_load       = 1'b1;
          w_next_state = START;
          w_next_tx    = 1'b0;
          w_next_busy  = 1'b1;
        end
      end
      START: begin
        w_shift      = 1'b1;
        w_next_state = DATA;
        w_next_tx    = w_ser_out;
      end
      DATA: begin
        w_shift = 1'b1;
        if (w_ser_done) begin
          if (r_par_en) begin
            w_next_state = PARITY;
            w_next_tx    = r_par;
          end else begin
            w_next_state = STOP;
          end
        end else begin
          w_next_tx = w_ser_out;
        end
      end
      PARITY: begin
        w_next_state = STOP;
      end
      STOP: begin
        if (w_stop_last) begin
          w_next_state = IDLE;
          w_next_busy  = 1'b0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_busy  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit controller and serializer for the UART transmitter. It accepts a parallel byte with a Data_Valid strobe and consumes the parity bit registered by the parity calculator on the same strobe. It emits a framed serial stream on TX_OUT: start bit, data LSB first, optional parity, stop bit(s). It sits between the upstream data source and the TX pin, in parallel with the parity stage.

## Interface
- DATA_WIDTH, 8, number of data bits per frame (5–9 supported)
- CLK  input  1  bit-rate clock; one cycle per serial bit
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  parallel data; sampled only on the accept cycle
- Data_Valid  input  1  request strobe; accepted only when busy=0
- PAR_EN  input  1  parity enable; sampled on the accept cycle
- par_bit  input  1  parity from the parity calculator; valid the cycle after the accept
- TX_OUT  output  1  registered serial line; idles high
- busy  output  1  registered; high from the start bit through the last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0.
  - On Data_Valid=1, load P_DATA into the shift register, latch PAR_EN, and go to START.
- START: TX_OUT=0, busy=1.
  - Capture par_bit into an internal register this cycle, so later upstream changes to par_bit cannot corrupt the frame.
  - Go to DATA with bit counter = 0.
- DATA: TX_OUT = shift_reg[0], then shift right. The counter increments each cycle.
  - After DATA_WIDTH cycles, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: TX_OUT = captured parity, then go to STOP.
- STOP: TX_OUT=1 for one cycle (two cycles with the macro), then go to IDLE.
- Data_Valid while busy=1 is ignored: no queuing, no state change. Upstream must hold or retry.
- P_DATA and PAR_EN changes after the accept cycle have no effect on the frame in flight.
- Reset asserted mid-frame: immediately go to IDLE, TX_OUT=1, busy=0, counter=0, shift register=0. The partial frame is abandoned.
- Reset values: TX_OUT=1, busy=0, state=IDLE, captured parity=0.

## Timing
- Data_Valid sampled high at edge n (busy=0) → after edge n: START, TX_OUT=0, busy=1.
- Frame length = 1 + DATA_WIDTH + PAR_EN + S cycles, where S=1 (or 2 with the macro).
  - DATA_WIDTH=8, parity on, S=1: 11 cycles.
- busy falls on the edge that enters IDLE. TX_OUT stays 1 in that cycle.
- Minimum inter-frame gap is one IDLE cycle. With Data_Valid held high, the next START begins one cycle after busy falls.
- par_bit must be stable in the START cycle. The parity calculator registers on the accept edge, which meets this.

## Configuration
- UART_TX_STOP2_EN defined: STOP lasts 2 cycles. Frame length +1.
- Undefined: a single stop cycle.
- busy covers all stop cycles in both cases.

## Structure
- Package uart_tx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), default DATA_WIDTH constant, counter width = $clog2(DATA_WIDTH).
- Sub-module uart_tx_serializer: shift register plus bit counter.
  - Ports: load, shift_en, P_DATA in; ser_out, ser_done out.
  - ser_done pulses on the last data bit.
- uart_tx_ctrl holds the FSM and the TX_OUT mux.

## Test plan
- P_DATA=0xA5, PAR_EN=1, par_bit=0 → TX_OUT = 0, 1,0,1,0,0,1,0,1, 0, 1; busy high for exactly 11 cycles.
- P_DATA=0x01, PAR_EN=0 → TX_OUT = 0, 1,0,0,0,0,0,0,0, 1; 10 cycles, no parity slot.
- Second Data_Valid with P_DATA=0xFF during the DATA state of a 0x3C frame → the 0x3C frame is unaltered, 0xFF is not sent, and busy stays high with no extension.
- Reset pulsed low at the 4th data bit → TX_OUT=1 and busy=0 in the same cycle. After release, Data_Valid with 0x55 produces a clean full frame.
- Data_Valid held high with 0x81 then 0x18 → exactly one idle-high cycle between the frames; both frames are bit-correct.
- With UART_TX_STOP2_EN, 0xA5 and parity on → 12-cycle frame ending in two high stop cycles.
